// File: rtl/sram_bus_arbiter.sv
// Two-master (inst/data) to one-slave arbiter for the SRAM-like req/addr_ok/data_ok bus.
// Optional macro SRAM_ARB_ROUND_ROBIN_EN: round-robin tie break instead of data-over-inst priority.
module sram_bus_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned CNT_W           = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inst_req,
  input  logic             inst_wr,
  input  logic [1:0]       inst_size,
  input  logic [3:0]       inst_wstrb,
  input  logic [31:0]      inst_addr,
  input  logic [31:0]      inst_wdata,
  output logic             inst_addr_ok,
  output logic             inst_data_ok,
  output logic [31:0]      inst_rdata,
  input  logic             data_req,
  input  logic             data_wr,
  input  logic [1:0]       data_size,
  input  logic [3:0]       data_wstrb,
  input  logic [31:0]      data_addr,
  input  logic [31:0]      data_wdata,
  output logic             data_addr_ok,
  output logic             data_data_ok,
  output logic [31:0]      data_rdata,
  output logic             s_req,
  output logic             s_wr,
  output logic [1:0]       s_size,
  output logic [3:0]       s_wstrb,
  output logic [31:0]      s_addr,
  output logic [31:0]      s_wdata,
  input  logic             s_addr_ok,
  input  logic             s_data_ok,
  input  logic [31:0]      s_rdata,
  output logic [CNT_W-1:0] outstanding,
  output logic             protocol_err
);

  typedef enum logic {M_INST = 1'b0, M_DATA = 1'b1} master_e;
  typedef enum logic {ST_FREE = 1'b0, ST_LOCKED = 1'b1} lock_e;

  lock_e                      state_q, state_d;
  master_e                    lock_id_q, lock_id_d;
  logic [MAX_OUTSTANDING-1:0] fifo_q, fifo_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       err_q, err_d;

  logic                       gnt_valid;
  master_e                    gnt_id;
  master_e                    tie_id;
  master_e                    head_id;
  logic                       violation;
  logic                       accept;
  logic                       resp_ok;
  logic                       spurious;
  logic [CNT_W-1:0]           slot;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  master_e rr_last_q, rr_last_d;

  assign rr_last_d = accept ? gnt_id : rr_last_q;
  assign tie_id    = (rr_last_q == M_INST) ? M_DATA : M_INST;

  always_ff @(posedge clk) begin
    if (rst) rr_last_q <= M_INST;
    else     rr_last_q <= rr_last_d;
  end
`else
  assign tie_id = M_DATA;
`endif

  // A held grant bypasses the full check: it was taken while the FIFO had room.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = M_INST;
    violation = 1'b0;
    if (!rst) begin
      if (state_q == ST_LOCKED) begin
        if ((lock_id_q == M_DATA) ? data_req : inst_req) begin
          gnt_valid = 1'b1;
          gnt_id    = lock_id_q;
        end else begin
          violation = 1'b1;
        end
      end else if ((cnt_q < CNT_W'(MAX_OUTSTANDING)) && (inst_req || data_req)) begin
        gnt_valid = 1'b1;
        if (inst_req && data_req) gnt_id = tie_id;
        else if (data_req)        gnt_id = M_DATA;
        else                      gnt_id = M_INST;
      end
    end
  end

  always_comb begin
    s_req   = 1'b0;
    s_wr    = 1'b0;
    s_size  = '0;
    s_wstrb = '0;
    s_addr  = '0;
    s_wdata = '0;
    if (gnt_valid) begin
      s_req = 1'b1;
      if (gnt_id == M_DATA) begin
        s_wr    = data_wr;
        s_size  = data_size;
        s_wstrb = data_wstrb;
        s_addr  = data_addr;
        s_wdata = data_wdata;
      end else begin
        s_wr    = inst_wr;
        s_size  = inst_size;
        s_wstrb = inst_wstrb;
        s_addr  = inst_addr;
        s_wdata = inst_wdata;
      end
    end
  end

  assign accept   = gnt_valid && s_addr_ok;
  assign resp_ok  = !rst && s_data_ok && (cnt_q != '0);
  assign spurious = !rst && s_data_ok && (cnt_q == '0);
  assign head_id  = master_e'(fifo_q[0]);

  assign inst_addr_ok = accept && (gnt_id == M_INST);
  assign data_addr_ok = accept && (gnt_id == M_DATA);
  assign inst_data_ok = resp_ok && (head_id == M_INST);
  assign data_data_ok = resp_ok && (head_id == M_DATA);
  assign inst_rdata   = s_rdata;
  assign data_rdata   = s_rdata;
  assign outstanding  = cnt_q;
  assign protocol_err = err_q;

  // Head sits at bit 0; a pop shifts down first so a same-cycle push lands one slot lower.
  assign slot = cnt_q - CNT_W'(resp_ok);

  always_comb begin
    fifo_d = resp_ok ? (fifo_q >> 1) : fifo_q;
    for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
      if (accept && (CNT_W'(i) == slot)) fifo_d[i] = gnt_id;
    end
    cnt_d = cnt_q + CNT_W'(accept) - CNT_W'(resp_ok);
    err_d = err_q || violation || spurious;
  end

  always_comb begin
    state_d   = ST_FREE;
    lock_id_d = lock_id_q;
    if (gnt_valid && !s_addr_ok) begin
      state_d   = ST_LOCKED;
      lock_id_d = gnt_id;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_FREE;
      lock_id_q <= M_INST;
      fifo_q    <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      lock_id_q <= lock_id_d;
      fifo_q    <= fifo_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Self-checking bench for sram_bus_arbiter: directed scenarios plus a randomized run
// against a queue-based reference model; honours SRAM_ARB_ROUND_ROBIN_EN when defined.
module tb_sram_bus_arbiter;
  localparam int unsigned MAXO = 2;
  localparam int unsigned CW   = 4;

  logic clk = 1'b0;
  logic rst;
  logic inst_req, inst_wr, data_req, data_wr;
  logic [1:0] inst_size, data_size;
  logic [3:0] inst_wstrb, data_wstrb;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic s_req, s_wr;
  logic [1:0] s_size;
  logic [3:0] s_wstrb;
  logic [31:0] s_addr, s_wdata;
  logic s_addr_ok, s_data_ok;
  logic [31:0] s_rdata;
  logic [CW-1:0] outstanding;
  logic protocol_err;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  logic [4:0] hs;
  assign hs = {s_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok};

  always #5 clk = ~clk;

  sram_bus_arbiter #(.MAX_OUTSTANDING(MAXO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_wstrb(s_wstrb), .s_addr(s_addr),
    .s_wdata(s_wdata), .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata),
    .outstanding(outstanding), .protocol_err(protocol_err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic idle;
    inst_req = 1'b0; inst_wr = 1'b0; inst_size = 2'd2; inst_wstrb = 4'hF;
    inst_addr = '0; inst_wdata = '0;
    data_req = 1'b0; data_wr = 1'b0; data_size = 2'd2; data_wstrb = 4'hF;
    data_addr = '0; data_wdata = '0;
    s_addr_ok = 1'b0; s_data_ok = 1'b0; s_rdata = '0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    inst_req = 1'b1; data_req = 1'b1; s_addr_ok = 1'b1; s_data_ok = 1'b1;
    inst_addr = 32'h1111_0000; data_addr = 32'h2222_0000;
    settle();
    n_tests++; if ({hs, s_addr} !== 37'd0) begin n_fail++; $display("FAIL reset_outputs: got hs=%b s_addr=%h, expected all zero", hs, s_addr); end
    tick();
    n_tests++; if ({outstanding, protocol_err} !== {CW'(0), 1'b0}) begin n_fail++; $display("FAIL reset_state: got outstanding=%0d err=%b, expected 0/0", outstanding, protocol_err); end
    idle();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_single_fetch;
    inst_req = 1'b1; inst_addr = 32'hBFC0_0000; inst_size = 2'd2;
    for (int c = 0; c < 2; c++) begin
      settle();
      n_tests++; if ({hs, s_addr} !== {5'b10000, 32'hBFC0_0000}) begin n_fail++; $display("FAIL fetch_wait%0d: got hs=%b s_addr=%h, expected 10000/bfc00000", c, hs, s_addr); end
      tick();
    end
    s_addr_ok = 1'b1;
    settle();
    n_tests++; if ({hs, s_size} !== {5'b11000, 2'd2}) begin n_fail++; $display("FAIL fetch_accept: got hs=%b size=%0d, expected 11000/2", hs, s_size); end
    tick();
    inst_req = 1'b0; s_addr_ok = 1'b0;
    n_tests++; if (outstanding !== CW'(1)) begin n_fail++; $display("FAIL fetch_outst1: got %0d expected 1", outstanding); end
    settle();
    n_tests++; if (hs !== 5'b00000) begin n_fail++; $display("FAIL fetch_gap: got hs=%b expected 00000", hs); end
    tick();
    s_data_ok = 1'b1; s_rdata = 32'h3C01_0001;
    settle();
    n_tests++; if ({hs, inst_rdata} !== {5'b00010, 32'h3C01_0001}) begin n_fail++; $display("FAIL fetch_resp: got hs=%b rdata=%h, expected 00010/3c010001", hs, inst_rdata); end
    tick();
    s_data_ok = 1'b0;
    settle();
    n_tests++; if ({hs, outstanding} !== {5'b00000, CW'(0)}) begin n_fail++; $display("FAIL fetch_done: got hs=%b outstanding=%0d, expected 00000/0", hs, outstanding); end
  endtask

  task automatic test_tie;
    do_reset();
    inst_req = 1'b1; inst_addr = 32'h0000_1000;
    data_req = 1'b1; data_addr = 32'h0000_2000;
    s_addr_ok = 1'b1;
    settle();
    n_tests++; if ({hs, s_addr} !== {5'b10100, 32'h2000}) begin n_fail++; $display("FAIL tie_first: got hs=%b s_addr=%h, expected 10100/2000", hs, s_addr); end
    tick();
    data_req = 1'b0;
    settle();
    n_tests++; if ({hs, s_addr} !== {5'b11000, 32'h1000}) begin n_fail++; $display("FAIL tie_second: got hs=%b s_addr=%h, expected 11000/1000", hs, s_addr); end
    tick();
    inst_req = 1'b0; s_addr_ok = 1'b0; s_data_ok = 1'b1;
    settle();
    n_tests++; if ({hs, outstanding} !== {5'b00001, CW'(2)}) begin n_fail++; $display("FAIL tie_order1: got hs=%b outstanding=%0d, expected 00001/2", hs, outstanding); end
    tick();
    settle();
    n_tests++; if (hs !== 5'b00010) begin n_fail++; $display("FAIL tie_order2: got hs=%b expected 00010", hs); end
    tick();
    s_data_ok = 1'b0;
  endtask

  task automatic test_lock;
    inst_req = 1'b1; inst_addr = 32'h0000_0100;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) begin data_req = 1'b1; data_addr = 32'h0000_0200; end
      settle();
      n_tests++; if ({hs, s_addr} !== {5'b10000, 32'h100}) begin n_fail++; $display("FAIL lock_hold%0d: got hs=%b s_addr=%h, expected 10000/100", c, hs, s_addr); end
      tick();
    end
    s_addr_ok = 1'b1;
    settle();
    n_tests++; if ({hs, s_addr} !== {5'b11000, 32'h100}) begin n_fail++; $display("FAIL lock_accept: got hs=%b s_addr=%h, expected 11000/100", hs, s_addr); end
    tick();
    inst_req = 1'b0;
    settle();
    n_tests++; if ({hs, s_addr} !== {5'b10100, 32'h200}) begin n_fail++; $display("FAIL lock_next: got hs=%b s_addr=%h, expected 10100/200", hs, s_addr); end
    tick();
    data_req = 1'b0; s_addr_ok = 1'b0; s_data_ok = 1'b1;
    settle();
    n_tests++; if (hs !== 5'b00010) begin n_fail++; $display("FAIL lock_resp1: got hs=%b expected 00010", hs); end
    tick();
    settle();
    n_tests++; if (hs !== 5'b00001) begin n_fail++; $display("FAIL lock_resp2: got hs=%b expected 00001", hs); end
    tick();
    s_data_ok = 1'b0;
  endtask

  task automatic test_full;
    inst_req = 1'b1; inst_addr = 32'h10; s_addr_ok = 1'b1;
    settle();
    n_tests++; if (hs !== 5'b11000) begin n_fail++; $display("FAIL full_acc1: got hs=%b expected 11000", hs); end
    tick();
    inst_req = 1'b0; data_req = 1'b1; data_addr = 32'h20;
    settle();
    n_tests++; if (hs !== 5'b10100) begin n_fail++; $display("FAIL full_acc2: got hs=%b expected 10100", hs); end
    tick();
    data_req = 1'b0; inst_req = 1'b1; inst_addr = 32'h30;
    settle();
    n_tests++; if ({hs, s_addr, outstanding} !== {5'b00000, 32'h0, CW'(2)}) begin n_fail++; $display("FAIL full_block: got hs=%b s_addr=%h outstanding=%0d, expected 00000/0/2", hs, s_addr, outstanding); end
    tick();
    s_addr_ok = 1'b0; s_data_ok = 1'b1;
    settle();
    n_tests++; if ({hs, outstanding} !== {5'b00010, CW'(2)}) begin n_fail++; $display("FAIL full_pop: got hs=%b outstanding=%0d, expected 00010/2", hs, outstanding); end
    tick();
    s_addr_ok = 1'b1;
    settle();
    n_tests++; if ({hs, s_addr, outstanding} !== {5'b11001, 32'h30, CW'(1)}) begin n_fail++; $display("FAIL full_pushpop: got hs=%b s_addr=%h outstanding=%0d, expected 11001/30/1", hs, s_addr, outstanding); end
    tick();
    inst_req = 1'b0; s_data_ok = 1'b0; data_req = 1'b1; data_addr = 32'h40;
    n_tests++; if (outstanding !== CW'(1)) begin n_fail++; $display("FAIL full_same: got %0d expected 1", outstanding); end
    settle();
    tick();
    data_req = 1'b0; s_addr_ok = 1'b0; s_data_ok = 1'b1;
    settle();
    n_tests++; if ({hs, outstanding} !== {5'b00010, CW'(2)}) begin n_fail++; $display("FAIL full_drain1: got hs=%b outstanding=%0d, expected 00010/2", hs, outstanding); end
    tick();
    settle();
    n_tests++; if (hs !== 5'b00001) begin n_fail++; $display("FAIL full_drain2: got hs=%b expected 00001", hs); end
    tick();
    s_data_ok = 1'b0;
  endtask

  task automatic test_routing;
    inst_req = 1'b1; inst_addr = 32'h500; s_addr_ok = 1'b1;
    tick();
    inst_req = 1'b0; data_req = 1'b1; data_addr = 32'h600;
    tick();
    data_req = 1'b0; s_addr_ok = 1'b0; s_data_ok = 1'b1; s_rdata = 32'hAAAA_0000;
    settle();
    n_tests++; if ({hs, inst_rdata} !== {5'b00010, 32'hAAAA_0000}) begin n_fail++; $display("FAIL route_inst: got hs=%b rdata=%h, expected 00010/aaaa0000", hs, inst_rdata); end
    tick();
    s_rdata = 32'h5555_FFFF;
    settle();
    n_tests++; if ({hs, data_rdata} !== {5'b00001, 32'h5555_FFFF}) begin n_fail++; $display("FAIL route_data: got hs=%b rdata=%h, expected 00001/5555ffff", hs, data_rdata); end
    tick();
    s_data_ok = 1'b0;
    n_tests++; if (outstanding !== CW'(0)) begin n_fail++; $display("FAIL route_empty: got %0d expected 0", outstanding); end
  endtask

  task automatic test_round_robin;
    logic [31:0] exp_addr [4];
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    exp_addr = '{32'h2000, 32'h1000, 32'h2000, 32'h1000};
`else
    exp_addr = '{32'h2000, 32'h2000, 32'h2000, 32'h2000};
`endif
    do_reset();
    inst_req = 1'b1; inst_addr = 32'h1000; data_req = 1'b1; data_addr = 32'h2000;
    s_addr_ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      s_data_ok = (k > 0);
      settle();
      n_tests++; if (s_addr !== exp_addr[k]) begin n_fail++; $display("FAIL rr_grant%0d: got s_addr=%h expected %h", k, s_addr, exp_addr[k]); end
      tick();
    end
    inst_req = 1'b0; data_req = 1'b0; s_addr_ok = 1'b0; s_data_ok = 1'b1;
    tick();
    s_data_ok = 1'b0;
    n_tests++; if ({outstanding, protocol_err} !== {CW'(0), 1'b0}) begin n_fail++; $display("FAIL rr_end: got outstanding=%0d err=%b, expected 0/0", outstanding, protocol_err); end
  endtask

  task automatic test_protocol_err;
    s_data_ok = 1'b1;
    settle();
    n_tests++; if (hs !== 5'b00000) begin n_fail++; $display("FAIL err_spurious_hs: got hs=%b expected 00000", hs); end
    tick();
    s_data_ok = 1'b0;
    for (int c = 0; c < 3; c++) begin
      inst_req = (c == 1); s_addr_ok = (c == 1);
      n_tests++; if (protocol_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky%0d: got %b expected 1", c, protocol_err); end
      tick();
    end
    inst_req = 1'b0; s_addr_ok = 1'b0; s_data_ok = 1'b1;
    tick();
    s_data_ok = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++; if (protocol_err !== 1'b0) begin n_fail++; $display("FAIL err_reset: got %b expected 0", protocol_err); end
    inst_req = 1'b1; inst_addr = 32'h700;
    tick();
    inst_req = 1'b0; data_req = 1'b1; data_addr = 32'h800;
    settle();
    n_tests++; if (hs[3] !== 1'b0) begin n_fail++; $display("FAIL err_drop_ack: got inst_addr_ok=%b expected 0", hs[3]); end
    tick();
    n_tests++; if ({protocol_err, outstanding} !== {1'b1, CW'(0)}) begin n_fail++; $display("FAIL err_drop: got err=%b outstanding=%0d, expected 1/0", protocol_err, outstanding); end
    settle();
    n_tests++; if ({hs, s_addr} !== {5'b10000, 32'h800}) begin n_fail++; $display("FAIL err_release: got hs=%b s_addr=%h, expected 10000/800", hs, s_addr); end
    do_reset();
  endtask

  task automatic test_random;
    bit mq[$];
    bit m_lock, m_owner, m_last;
    bit g_valid, g_id, acc, rsp;
    logic [4:0] exp_hs;
    logic [70:0] exp_bus, got_bus;
    m_lock = 1'b0; m_owner = 1'b0; m_last = 1'b0;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!inst_req && ($urandom_range(0, 2) == 0)) begin
        inst_req = 1'b1; inst_addr = $urandom; inst_wdata = $urandom; inst_wr = 1'($urandom);
        inst_size = 2'($urandom_range(0, 2)); inst_wstrb = 4'($urandom);
      end
      if (!data_req && ($urandom_range(0, 2) == 0)) begin
        data_req = 1'b1; data_addr = $urandom; data_wdata = $urandom; data_wr = 1'($urandom);
        data_size = 2'($urandom_range(0, 2)); data_wstrb = 4'($urandom);
      end
      s_addr_ok = 1'($urandom_range(0, 1));
      s_data_ok = (mq.size() > 0) && ($urandom_range(0, 1) == 1);
      s_rdata = $urandom;
      g_valid = 1'b0; g_id = 1'b0;
      if (m_lock) begin
        g_valid = 1'b1; g_id = m_owner;
      end else if ((mq.size() < MAXO) && (inst_req || data_req)) begin
        g_valid = 1'b1;
        if (inst_req && data_req) begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
          g_id = !m_last;
`else
          g_id = 1'b1;
`endif
        end else begin
          g_id = data_req;
        end
      end
      acc = g_valid && s_addr_ok;
      rsp = s_data_ok && (mq.size() > 0);
      exp_hs = {g_valid, acc && !g_id, acc && g_id, rsp && !mq[0], rsp && mq[0]};
      if (!g_valid)  exp_bus = '0;
      else if (g_id) exp_bus = {data_wr, data_size, data_wstrb, data_addr, data_wdata};
      else           exp_bus = {inst_wr, inst_size, inst_wstrb, inst_addr, inst_wdata};
      settle();
      got_bus = {s_wr, s_size, s_wstrb, s_addr, s_wdata};
      n_tests++;
      if ({hs, got_bus, outstanding, protocol_err, inst_rdata, data_rdata} !==
          {exp_hs, exp_bus, CW'(mq.size()), 1'b0, s_rdata, s_rdata}) begin
        n_fail++;
        $display("FAIL rand_cyc%0d: got hs=%b bus=%h outst=%0d err=%b, expected hs=%b bus=%h outst=%0d err=0",
                 cyc, hs, got_bus, outstanding, protocol_err, exp_hs, exp_bus, mq.size());
      end
      tick();
      if (rsp) void'(mq.pop_front());
      if (acc) begin
        mq.push_back(g_id);
        m_last = g_id;
        if (g_id) data_req = 1'b0; else inst_req = 1'b0;
      end
      m_lock  = g_valid && !acc;
      m_owner = g_id;
    end
    do_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;
    test_reset();
    test_single_fetch();
    test_tie();
    test_lock();
    test_full();
    test_routing();
    test_round_robin();
    test_protocol_err();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
